// File: rtl/gpio_bank_ctrl.sv
// Multi-bank GPIO controller with a per-bank register file, input synchronisers and
// edge-triggered sticky interrupt status. Pad tristates live at chip top.
module gpio_bank_ctrl #(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANK_BW     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_BW     = $clog2(NUM_BANKS) + 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  input  logic                           we,
  input  logic [ADDR_BW-1:0]             addr,
  input  logic [BANK_BW-1:0]             wdata,
  output logic [BANK_BW-1:0]             rdata,
  output logic                           ack,
  input  logic [NUM_BANKS*BANK_BW-1:0]   gpio_in,
  output logic [NUM_BANKS*BANK_BW-1:0]   gpio_out,
  output logic [NUM_BANKS*BANK_BW-1:0]   gpio_oe,
  output logic [NUM_BANKS-1:0]           irq
);

  localparam int unsigned PinW = NUM_BANKS * BANK_BW;

  typedef logic [NUM_BANKS-1:0][BANK_BW-1:0] bank_regs_t;

  bank_regs_t data_out_q, data_out_d;
  bank_regs_t dir_q, dir_d;
  bank_regs_t rise_en_q, rise_en_d;
  bank_regs_t fall_en_q, fall_en_d;
  bank_regs_t status_q, status_d;

  logic [SYNC_STAGES-1:0][PinW-1:0] sync_q;
  logic [PinW-1:0]                  prev_q;
  logic [PinW-1:0]                  sync_out;
  logic [PinW-1:0]                  set_term;
  logic [NUM_BANKS-1:0]             irq_q, irq_d;
  logic [BANK_BW-1:0]               rdata_q, rdata_d;
  logic                             ack_q;
  logic [ADDR_BW-1:0]               bank_sel;
  logic [2:0]                       reg_sel;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign bank_sel = addr >> 3;
  assign reg_sel  = addr[2:0];

  // Edges are seen on every pin regardless of direction, so output pins can loop back.
  assign set_term = (sync_out & ~prev_q & rise_en_q) | (~sync_out & prev_q & fall_en_q);

  always_comb begin
    logic                hit;
    logic [BANK_BW-1:0]  w1c;
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    status_d   = status_q;
    irq_d      = '0;
    rdata_d    = '0;
    hit        = 1'b0;
    w1c        = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      hit = req && (bank_sel == ADDR_BW'(b));
      w1c = '0;
      if (hit && we) begin
        case (reg_sel)
          3'd0:    data_out_d[b] = wdata;
          3'd1:    dir_d[b]      = wdata;
          3'd3:    rise_en_d[b]  = wdata;
          3'd4:    fall_en_d[b]  = wdata;
          3'd5:    w1c           = wdata;
          default: ;
        endcase
      end else if (hit) begin
        case (reg_sel)
          3'd0:    rdata_d = data_out_q[b];
          3'd1:    rdata_d = dir_q[b];
          3'd2:    rdata_d = sync_out[b*BANK_BW +: BANK_BW];
          3'd3:    rdata_d = rise_en_q[b];
          3'd4:    rdata_d = fall_en_q[b];
          3'd5:    rdata_d = status_q[b];
          default: rdata_d = '0;
        endcase
      end
      // A new edge in the same cycle as a clear keeps the bit set.
      status_d[b] = (status_q[b] & ~w1c) | set_term[b*BANK_BW +: BANK_BW];
      irq_d[b]    = |status_q[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      irq_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      ack_q      <= req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_out;
    end
  end

  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;
  assign rdata    = rdata_q;
  assign ack      = ack_q;

endmodule
